// File: rtl/pwm_generator.sv
// Double-buffered PWM generator with period-boundary updates and a completion pulse per period.
// Define PWM_DEADTIME_EN to force idle periods on direction reversal (H-bridge dead-time).
module pwm_generator #(
   parameter int unsigned PRESCALE         = 4,
   parameter int unsigned DEADTIME_PERIODS = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pwm_enable,
   input  logic       pwm_update,
   input  logic [7:0] pwm_ratio,
   input  logic       pwm_direction,
   output logic       pwm_done,
   output logic       pwm_out,
   output logic       dir_out,
   output logic [7:0] active_ratio
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   if (PRESCALE < 1 || DEADTIME_PERIODS < 1) begin : g_param_check
      $error("pwm_generator: PRESCALE and DEADTIME_PERIODS must be >= 1");
   end

`ifdef PWM_DEADTIME_EN
   localparam int unsigned DW = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDead
   } state_e;

   logic [DW-1:0] dead_cnt;
`else
   typedef enum logic [0:0] {
      StIdle,
      StRun
   } state_e;
`endif

   state_e        state;
   logic [PW-1:0] prescale_cnt;
   logic [PW-1:0] prescale_nxt;
   logic [7:0]    period_cnt;
   logic [7:0]    period_nxt;
   logic [7:0]    shadow_ratio;
   logic          shadow_dir;
   logic          tick;
   logic          boundary;

   always_comb begin
      tick         = (prescale_cnt == PW'(PRESCALE - 1));
      boundary     = tick && (period_cnt == 8'd254);
      prescale_nxt = tick ? '0 : prescale_cnt + PW'(1);
      if (boundary) begin
         period_nxt = 8'd0;
      end else if (tick) begin
         period_nxt = period_cnt + 8'd1;
      end else begin
         period_nxt = period_cnt;
      end
   end

   // pwm_out is derived from next-state counter/ratio so it lines up with period_cnt.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= StIdle;
         prescale_cnt <= '0;
         period_cnt   <= 8'd0;
         shadow_ratio <= 8'd0;
         shadow_dir   <= 1'b0;
         active_ratio <= 8'd0;
         dir_out      <= 1'b0;
         pwm_out      <= 1'b0;
         pwm_done     <= 1'b0;
`ifdef PWM_DEADTIME_EN
         dead_cnt     <= '0;
`endif
      end else if (!pwm_enable) begin
         state        <= StIdle;
         prescale_cnt <= '0;
         period_cnt   <= 8'd0;
         shadow_ratio <= 8'd0;
         active_ratio <= 8'd0;
         pwm_out      <= 1'b0;
         pwm_done     <= 1'b0;
`ifdef PWM_DEADTIME_EN
         dead_cnt     <= '0;
`endif
      end else begin
         pwm_done <= 1'b0;
         if (pwm_update) begin
            shadow_ratio <= pwm_ratio;
            shadow_dir   <= pwm_direction;
         end
         case (state)
            StIdle: begin
               prescale_cnt <= '0;
               period_cnt   <= 8'd0;
               pwm_out      <= 1'b0;
               if (pwm_update) begin
                  state        <= StRun;
                  active_ratio <= pwm_ratio;
                  dir_out      <= pwm_direction;
                  pwm_out      <= (pwm_ratio != 8'd0);
               end
            end
            StRun: begin
               prescale_cnt <= prescale_nxt;
               period_cnt   <= period_nxt;
               pwm_out      <= (period_nxt < active_ratio);
               if (boundary) begin
                  pwm_done <= 1'b1;
`ifdef PWM_DEADTIME_EN
                  if (shadow_dir != dir_out) begin
                     state    <= StDead;
                     dead_cnt <= '0;
                     pwm_out  <= 1'b0;
                  end else begin
                     active_ratio <= shadow_ratio;
                     dir_out      <= shadow_dir;
                     pwm_out      <= (shadow_ratio != 8'd0);
                  end
`else
                  active_ratio <= shadow_ratio;
                  dir_out      <= shadow_dir;
                  pwm_out      <= (shadow_ratio != 8'd0);
`endif
               end
            end
`ifdef PWM_DEADTIME_EN
            StDead: begin
               prescale_cnt <= prescale_nxt;
               period_cnt   <= period_nxt;
               pwm_out      <= 1'b0;
               if (boundary) begin
                  pwm_done <= 1'b1;
                  // Exit uses whatever is in shadow now, even if direction changed again.
                  if (dead_cnt == DW'(DEADTIME_PERIODS - 1)) begin
                     state        <= StRun;
                     active_ratio <= shadow_ratio;
                     dir_out      <= shadow_dir;
                     pwm_out      <= (shadow_ratio != 8'd0);
                  end else begin
                     dead_cnt <= dead_cnt + DW'(1);
                  end
               end
            end
`endif
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
